// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V boot/run sequencer: state encodings,
// error codes, default halt address and a saturating-increment helper.
package riscv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_HALT    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_WDOG = 2'b10;

  localparam logic [31:0] HALT_ADDR_DEFAULT  = 32'h0000_0FFC;
  localparam logic [31:0] WDOG_LIMIT_DEFAULT = 32'd100000;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/riscv_boot_loadctr.sv
// IMEM word counter with end-of-memory flag, plus the down-counter that
// times the core reset window after the last program word.
module riscv_boot_loadctr #(
  parameter int unsigned IMEM_AW    = 8,
  parameter int unsigned REL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               word_clr,
  input  logic               word_inc,
  output logic [IMEM_AW-1:0] word_addr,
  output logic               word_at_end,
  input  logic               rel_load,
  input  logic               rel_dec,
  output logic               rel_done
);

  localparam int unsigned    REL_W    = $clog2(REL_CYCLES + 1);
  localparam logic [REL_W-1:0] REL_INIT = REL_W'(REL_CYCLES - 1);

  logic [IMEM_AW-1:0] word_q;
  logic [REL_W-1:0]   rel_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (word_clr) begin
      word_q <= '0;
    end else if (word_inc) begin
      word_q <= word_q + 1'b1;
    end
  end

  // Loaded with REL_CYCLES-1 so that the window, including the terminal zero
  // count, spans exactly REL_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q <= '0;
    end else if (rel_load) begin
      rel_q <= REL_INIT;
    end else if (rel_dec && (rel_q != '0)) begin
      rel_q <= rel_q - 1'b1;
    end
  end

  assign word_addr   = word_q;
  assign word_at_end = &word_q;
  assign rel_done    = (rel_q == '0);

endmodule

// File: rtl/riscv_boot_ctrl.sv
// Boot/run sequencer: loads IMEM, releases the core, gates stores and
// captures the halt exit code. Optional watchdog: RISCV_BOOT_WDOG_EN.
module riscv_boot_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_AW    = 8,
  parameter int unsigned REL_CYCLES = 4,
  parameter logic [31:0] HALT_ADDR  = HALT_ADDR_DEFAULT,
  parameter logic [31:0] WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
  input  logic               i_CLK,
  input  logic               i_Reset,
  input  logic               i_Start,
  input  logic               i_LoadValid,
  input  logic [31:0]        i_LoadData,
  input  logic               i_LoadLast,
  output logic               o_LoadReady,
  output logic               o_IMemWE,
  output logic [IMEM_AW-1:0] o_IMemAddr,
  output logic [31:0]        o_IMemWData,
  output logic               o_CoreReset,
  input  logic               i_CoreMemWrite,
  input  logic [31:0]        i_CoreALUResult,
  input  logic [31:0]        i_CoreWriteData,
  output logic               o_DMemWE,
  output logic               o_Done,
  output logic [31:0]        o_ExitCode,
  output logic [1:0]         o_Err,
  output logic [31:0]        o_CycleCount,
  output logic [2:0]         o_State
);

`ifdef RISCV_BOOT_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [1:0]         err_q;
  logic [31:0]        exit_q;
  logic [31:0]        cycle_q;
  logic [31:0]        cycle_next;

  logic               xfer;
  logic               halt_hit;
  logic               wdog_hit;
  logic               ovf_hit;
  logic               word_clr;
  logic               rel_load;
  logic               rel_dec;
  logic [IMEM_AW-1:0] word_addr;
  logic               word_at_end;
  logic               rel_done;

  riscv_boot_loadctr #(
    .IMEM_AW    (IMEM_AW),
    .REL_CYCLES (REL_CYCLES)
  ) u_loadctr (
    .clk         (i_CLK),
    .rst_n       (i_Reset),
    .word_clr    (word_clr),
    .word_inc    (xfer),
    .word_addr   (word_addr),
    .word_at_end (word_at_end),
    .rel_load    (rel_load),
    .rel_dec     (rel_dec),
    .rel_done    (rel_done)
  );

  assign xfer       = (state_q == ST_LOAD) && i_LoadValid;
  assign ovf_hit    = xfer && !i_LoadLast && word_at_end;
  assign halt_hit   = (state_q == ST_RUN) && i_CoreMemWrite &&
                      (i_CoreALUResult == HALT_ADDR);
  assign cycle_next = sat_inc32(cycle_q);
  // The halt store takes priority when it lands on the limit cycle.
  assign wdog_hit   = WDOG_EN && (state_q == ST_RUN) && !halt_hit &&
                      (cycle_next == WDOG_LIMIT);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    word_clr = 1'b0;
    rel_load = 1'b0;
    rel_dec  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        if (i_Start) begin
          state_d  = ST_LOAD;
          word_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (i_LoadLast) begin
            state_d  = ST_RELEASE;
            rel_load = 1'b1;
          end else if (word_at_end) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_RELEASE: begin
        if (rel_done) begin
          state_d = ST_RUN;
        end else begin
          rel_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_hit) begin
          state_d = ST_HALT;
        end else if (wdog_hit) begin
          state_d = ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A restart (any accepted i_Start) wipes the results of the previous run.
  always_ff @(posedge i_CLK or negedge i_Reset) begin
    if (!i_Reset) begin
      err_q   <= ERR_NONE;
      exit_q  <= '0;
      cycle_q <= '0;
    end else if (word_clr) begin
      err_q   <= ERR_NONE;
      exit_q  <= '0;
      cycle_q <= '0;
    end else begin
      if (state_q == ST_RUN) begin
        cycle_q <= cycle_next;
      end
      if (halt_hit) begin
        exit_q <= i_CoreWriteData;
      end
      if (ovf_hit) begin
        err_q <= ERR_OVF;
      end else if (wdog_hit) begin
        err_q <= ERR_WDOG;
      end
    end
  end

  assign o_LoadReady  = (state_q == ST_LOAD);
  assign o_IMemWE     = xfer;
  assign o_IMemAddr   = word_addr;
  assign o_IMemWData  = xfer ? i_LoadData : 32'd0;
  assign o_CoreReset  = (state_q != ST_RUN);
  assign o_DMemWE     = (state_q == ST_RUN) && i_CoreMemWrite && !halt_hit;
  assign o_Done       = (state_q == ST_HALT);
  assign o_ExitCode   = exit_q;
  assign o_Err        = err_q;
  assign o_CycleCount = cycle_q;
  assign o_State      = state_q;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Randomized self-checking bench for riscv_boot_ctrl against a behavioural
// model of load, release, run/halt, overflow and watchdog behaviour.
module tb_riscv_boot_ctrl;

  localparam int unsigned AW    = 2;
  localparam int unsigned REL   = 4;
  localparam logic [31:0] HALT  = 32'h0000_0FFC;
  localparam logic [31:0] WLIM  = 32'd10;
  localparam int          S_IDLE = 0, S_LOAD = 1, S_REL = 2, S_RUN = 3,
                          S_HALT = 4, S_ERR = 5;

`ifdef RISCV_BOOT_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          lvalid = 1'b0;
  logic [31:0]   ldata = '0;
  logic          llast = 1'b0;
  logic          lready;
  logic          iwe;
  logic [AW-1:0] iaddr;
  logic [31:0]   iwdata;
  logic          crst;
  logic          mw = 1'b0;
  logic [31:0]   alu = '0;
  logic [31:0]   wd = '0;
  logic          dwe;
  logic          done;
  logic [31:0]   exit_code;
  logic [1:0]    err;
  logic [31:0]   cyc;
  logic [2:0]    state;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int          exp_state = S_IDLE;
  logic [31:0] run_cyc   = '0;
  logic [31:0] exp_exit  = '0;
  logic [1:0]  exp_err   = '0;
  logic [31:0] prog[$];

  riscv_boot_ctrl #(
    .IMEM_AW    (AW),
    .REL_CYCLES (REL),
    .HALT_ADDR  (HALT),
    .WDOG_LIMIT (WLIM)
  ) dut (
    .i_CLK           (clk),
    .i_Reset         (rst_n),
    .i_Start         (start),
    .i_LoadValid     (lvalid),
    .i_LoadData      (ldata),
    .i_LoadLast      (llast),
    .o_LoadReady     (lready),
    .o_IMemWE        (iwe),
    .o_IMemAddr      (iaddr),
    .o_IMemWData     (iwdata),
    .o_CoreReset     (crst),
    .i_CoreMemWrite  (mw),
    .i_CoreALUResult (alu),
    .i_CoreWriteData (wd),
    .o_DMemWE        (dwe),
    .o_Done          (done),
    .o_ExitCode      (exit_code),
    .o_Err           (err),
    .o_CycleCount    (cyc),
    .o_State         (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".state"}, state, exp_state);
    check({tag, ".cycles"}, cyc, run_cyc);
    check({tag, ".err"}, err, exp_err);
    check({tag, ".exit"}, exit_code, exp_exit);
    check({tag, ".done"}, done, exp_state == S_HALT);
    check({tag, ".core_reset"}, crst, exp_state != S_RUN);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 0; lvalid = 0; ldata = '0; llast = 0;
    mw = 0; alu = '0; wd = '0;
    #2;
    exp_state = S_IDLE; run_cyc = '0; exp_exit = '0; exp_err = '0;
    check_regs("reset");
    check("reset.load_ready", lready, 0);
    check("reset.imem_we", iwe, 0);
    check("reset.imem_addr", iaddr, 0);
    check("reset.imem_wdata", iwdata, 0);
    check("reset.dmem_we", dwe, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_state = S_LOAD; run_cyc = '0; exp_exit = '0; exp_err = '0;
    check_regs("start");
    check("start.load_ready", lready, 1);
  endtask

  // Sends n words from prog; with_last marks the final one. Gaps in valid
  // are inserted at random when gappy is set; i_Start is toggled to show it
  // is ignored while loading.
  task automatic load_words(input int n, input bit with_last, input bit gappy);
    int idx = 0;
    while (idx < n) begin
      lvalid = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
      ldata  = prog[idx];
      llast  = with_last && (idx == n - 1);
      start  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("load.ready", lready, 1);
      check("load.core_reset", crst, 1);
      check("load.imem_we", iwe, lvalid);
      if (lvalid) begin
        check("load.imem_addr", iaddr, idx);
        check("load.imem_wdata", iwdata, prog[idx]);
      end
      tick();
      start = 1'b0;
      if (lvalid) idx++;
    end
    lvalid = 0; llast = 0;
    exp_state = with_last ? S_REL : S_ERR;
    if (!with_last) exp_err = 2'b01;
    check("load.end_state", state, exp_state);
    check("load.end_err", err, exp_err);
  endtask

  // Counts edges from the last accept until the core leaves reset.
  task automatic measure_release();
    int n = 0;
    while (crst && n < 50) begin
      start = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    start = 1'b0;
    check("release.cycles", n, REL);
    exp_state = S_RUN;
    check("release.state", state, S_RUN);
  endtask

  task automatic run_one(input logic mw_i, input logic [31:0] alu_i, input logic [31:0] wd_i);
    mw = mw_i; alu = alu_i; wd = wd_i;
    start = (exp_state == S_RUN) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    check("run.dmem_we", dwe, (exp_state == S_RUN) && mw_i && (alu_i != HALT));
    if (exp_state == S_RUN) begin
      if (run_cyc != 32'hFFFF_FFFF) run_cyc = run_cyc + 1;
      if (mw_i && alu_i == HALT) begin
        exp_state = S_HALT;
        exp_exit  = wd_i;
      end else if (WDOG_ON && run_cyc == WLIM) begin
        exp_state = S_ERR;
        exp_err   = 2'b10;
      end
    end
    tick();
    mw = 0; start = 0;
    check_regs("run");
  endtask

  task automatic run_plain(input int n);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      a = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        run_one(1'b0, HALT, $urandom);
      end else begin
        if (a == HALT) a = a ^ 32'h4;
        run_one(1'($urandom_range(0, 1)), a, $urandom);
      end
    end
  endtask

  task automatic fill_prog(input int n);
    prog.delete();
    for (int k = 0; k < n; k++) prog.push_back($urandom);
  endtask

  initial begin
    apply_reset();

    // Directed program with valid held
    prog = '{32'h0050_0093, 32'h0010_0113, 32'h0020_8233};
    start_load();
    load_words(3, 1'b1, 1'b0);
    measure_release();

    // Ordinary store passes, halt store is swallowed and captured
    run_one(1'b1, 32'h0000_0010, 32'h1234_5678);
    run_one(1'b1, HALT, 32'h0000_002A);

    // Random restarts from HALT
    for (int it = 0; it < 4; it++) begin
      fill_prog($urandom_range(1, 4));
      start_load();
      load_words(prog.size(), 1'b1, 1'b1);
      measure_release();
      run_plain($urandom_range(0, 7));
      run_one(1'b1, HALT, $urandom);
    end

    // Halt on the watchdog-limit cycle: halt wins
    fill_prog(2);
    start_load();
    load_words(2, 1'b1, 1'b1);
    measure_release();
    run_plain(9);
    run_one(1'b1, HALT, 32'hCAFE_0001);

    // Watchdog: no halt store for 15 RUN cycles
    fill_prog(1);
    start_load();
    load_words(1, 1'b1, 1'b0);
    measure_release();
    run_plain(15);
    apply_reset();

    // Overflow: four words without last into a 4-word IMEM
    fill_prog(4);
    start_load();
    load_words(4, 1'b0, 1'b1);
    check("ovf.load_ready", lready, 0);
    lvalid = 1'b1;
    @(negedge clk);
    check("ovf.no_write", iwe, 0);
    tick();
    lvalid = 1'b0;
    check_regs("ovf.hold");

    // Restart from ERROR, then reset in the middle of a gappy load
    begin
      logic [2:0] pat;
      int nw;
      pat = 3'b101;
      nw  = 0;
      start_load();
      for (int k = 0; k < 3; k++) begin
        lvalid = pat[k];
        ldata  = $urandom;
        llast  = 1'b0;
        @(negedge clk);
        check("midrst.imem_we", iwe, pat[k]);
        if (pat[k]) check("midrst.imem_addr", iaddr, nw);
        tick();
        if (pat[k]) nw++;
      end
      lvalid = 1'b1;
      rst_n  = 1'b0;
      #1;
      check("midrst.state", state, S_IDLE);
      check("midrst.core_reset", crst, 1);
      check("midrst.no_write", iwe, 0);
      lvalid = 1'b0;
      apply_reset();
    end
    fill_prog(2);
    start_load();
    load_words(2, 1'b1, 1'b1);
    measure_release();
    run_one(1'b1, HALT, 32'h0000_0055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/riscv_boot_ctrl.md
Name: riscv_boot_ctrl

Overview:
Boot/run sequencer for the single-cycle RISC-V core. It holds the core in reset, streams a program into instruction memory over a valid/ready load port, and releases the core after a fixed reset window. While the core runs, it gates data-memory writes and detects a halt store to a reserved address, capturing the exit code. It sits between the testbench/loader and the core top, and owns the core reset plus the IMEM write port.

Parameters:
IMEM_AW, 8, IMEM word-address width; depth = 2**IMEM_AW words
REL_CYCLES, 4, cycles the core reset is held after load completes (>=1)
HALT_ADDR, 32'h0000_0FFC, byte address whose store halts the core
WDOG_LIMIT, 32'd100000, RUN-cycle limit (used only with the watchdog feature)

Ports:
i_CLK  in  1  clock, rising edge
i_Reset  in  1  asynchronous active-low reset
i_Start  in  1  begin load; sampled in IDLE, HALT, ERROR
i_LoadValid  in  1  load word valid
i_LoadData  in  32  program word
i_LoadLast  in  1  marks final program word
o_LoadReady  out  1  load port ready
o_IMemWE  out  1  IMEM write enable
o_IMemAddr  out  IMEM_AW  IMEM word address
o_IMemWData  out  32  IMEM write data
o_CoreReset  out  1  active-high reset to core
i_CoreMemWrite  in  1  core store strobe
i_CoreALUResult  in  32  core store address
i_CoreWriteData  in  32  core store data
o_DMemWE  out  1  gated store strobe to data memory
o_Done  out  1  halted normally
o_ExitCode  out  32  data of the halting store
o_Err  out  2  00 none, 01 load overflow, 10 watchdog
o_CycleCount  out  32  RUN cycles, saturating
o_State  out  3  current state encoding

Behaviour:
- States and encodings: IDLE=0, LOAD=1, RELEASE=2, RUN=3, HALT=4, ERROR=5. On reset: IDLE. All outputs are 0 except o_CoreReset=1.
- IDLE: o_CoreReset=1. On i_Start -> LOAD.
- LOAD: o_LoadReady=1 and o_CoreReset=1. A word transfers on valid&ready.
  - On transfer: combinationally, o_IMemWE=1, o_IMemAddr=word counter, o_IMemWData=i_LoadData. The counter then increments.
  - Transfer with i_LoadLast -> RELEASE.
  - Transfer at address 2**IMEM_AW-1 without i_LoadLast: the word is written, then -> ERROR with o_Err=01.
  - Zero-length loads are impossible, because a word must carry i_LoadLast.
- RELEASE: o_CoreReset=1 for exactly REL_CYCLES cycles, counted by a down-counter. Then -> RUN.
- RUN: o_CoreReset=0. o_CycleCount increments every RUN cycle and saturates at 32'hFFFF_FFFF.
  - Halt condition: i_CoreMemWrite=1 and i_CoreALUResult==HALT_ADDR.
  - On halt, the same cycle: o_DMemWE=0 and i_CoreWriteData is registered into o_ExitCode. Next state is HALT.
  - Otherwise o_DMemWE=i_CoreMemWrite.
  - Outside RUN, o_DMemWE=0.
- HALT: o_CoreReset=1 (core frozen) and o_Done=1. o_ExitCode and o_CycleCount hold.
- ERROR: o_CoreReset=1 and o_Err holds its code.
- Restart: i_Start in HALT or ERROR -> LOAD. This clears the word counter, o_Done, o_Err, o_ExitCode and o_CycleCount.
- i_Start is ignored in LOAD, RELEASE and RUN.
- Reset mid-operation (any state): immediately IDLE with the reset values above. A partial IMEM load is abandoned with no extra writes.
- IMEM write is combinational from the handshake, so load latency is 0 cycles.
- Core release latency = REL_CYCLES cycles after the cycle the last word is accepted.

Optional Feature:
- Macro: RISCV_BOOT_WDOG_EN.
- Defined: in RUN, when o_CycleCount reaches WDOG_LIMIT without a halt -> ERROR with o_Err=10, core reset asserted.
  - If the halt store and the limit occur in the same cycle, the halt wins.
- Undefined: no watchdog, and o_Err never takes the value 10.

Decomposition:
- Shared package riscv_pkg holds:
  - the state enum/localparams (IDLE..ERROR);
  - the error-code constants (ERR_NONE, ERR_OVF, ERR_WDOG);
  - the default HALT_ADDR.
- One natural sub-module, riscv_boot_loadctr: the IMEM word counter with its overflow flag and the REL_CYCLES down-counter. The FSM stays in the top.

Test Plan:
- Reset, i_Start, 3 words (0x00500093, 0x00100113, last 0x00208233) with valid held -> IMEM writes at addresses 0,1,2; o_CoreReset falls exactly 4 cycles after the last accept.
- In RUN, core stores 0x2A to 0x0FFC -> o_DMemWE=0 that cycle, next cycle o_State=4, o_Done=1, o_ExitCode=0x2A, o_CoreReset=1.
- In RUN, store to 0x0010 -> o_DMemWE=1, state stays RUN.
- IMEM_AW=2, send 4 words with no last -> 4 writes (addresses 0..3), then o_State=5, o_Err=01.
- With i_LoadValid toggling 1,0,1 and i_Reset pulsed low mid-LOAD -> writes only on valid cycles; reset gives IDLE, o_CoreReset=1, next load restarts at address 0.
- With RISCV_BOOT_WDOG_EN and WDOG_LIMIT=10, no halt store -> ERROR with o_Err=10 when o_CycleCount=10; without the macro, it stays in RUN.
